// File: rtl/risc_imm_pkg.sv
// risc_imm_pkg: shared types and helpers for the immediate stage.
//   imm_fmt_t   - 3-bit immediate format code (6 is reserved, decoded as NONE)
//   OP_IMM..SYSTEM - RV32I/RV64I major opcodes that carry an immediate
//   imm_ext()   - extends the immediate of a given format to 64 bits; callers
//                 truncate to their XLEN
package risc_imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_J    = 3'd3,
    FMT_U    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // Sign-extends to 64 bits (zimm is zero-extended). For width 32 the upper
  // word is cleared so the result reads the same whether or not it is cut.
  function automatic logic [63:0] imm_ext(input imm_fmt_t fmt,
                                          input logic [31:0] instr,
                                          input int unsigned width);
    logic [63:0] r;
    case (fmt)
      FMT_I:   r = {{52{instr[31]}}, instr[31:20]};
      FMT_S:   r = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   r = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      FMT_J:   r = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      FMT_U:   r = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_Z:   r = {59'b0, instr[19:15]};
      default: r = '0;
    endcase
    if (width == 32) r[63:32] = '0;
    return r;
  endfunction

endpackage

// File: rtl/risc_imm_decode.sv
// risc_imm_decode: combinational format select, immediate extension and
// PC-relative target for one instruction.
//   instr/pc/ext_src -> imm, fmt, target (pc + imm), tgt_valid, illegal
module risc_imm_decode
  import risc_imm_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit USE_EXT_SRC = 1'b0
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [2:0]            ext_src,
  output logic [DATA_WIDTH-1:0] imm,
  output imm_fmt_t              fmt,
  output logic [DATA_WIDTH-1:0] target,
  output logic                  tgt_valid,
  output logic                  illegal
);

  logic [6:0] opc;
  imm_fmt_t   fmt_dec;

  always_comb begin
    opc     = instr[6:0];
    fmt_dec = FMT_NONE;
    case (opc)
      OP_IMM, LOAD, JALR: fmt_dec = FMT_I;
      STORE:              fmt_dec = FMT_S;
      BRANCH:             fmt_dec = FMT_B;
      JAL:                fmt_dec = FMT_J;
      LUI, AUIPC:         fmt_dec = FMT_U;
      // funct3[2] separates the CSR*I forms (zimm) from the register forms
      SYSTEM:             fmt_dec = instr[14] ? FMT_Z : FMT_I;
      default:            fmt_dec = FMT_NONE;
    endcase

    if (USE_EXT_SRC)
      fmt = (ext_src == 3'd6) ? FMT_NONE : imm_fmt_t'(ext_src);
    else
      fmt = fmt_dec;

    imm       = DATA_WIDTH'(imm_ext(fmt, instr, DATA_WIDTH));
    target    = pc + imm;
    illegal   = (fmt == FMT_NONE);
    // AUIPC is only recognisable from the opcode, so an external format
    // cannot flag it.
    tgt_valid = (fmt == FMT_B) || (fmt == FMT_J) ||
                (!USE_EXT_SRC && (opc == AUIPC));
  end

endmodule

// File: rtl/risc_imm_stage.sv
// risc_imm_stage: pipelined immediate generator with valid/ready handshake.
//   in_*   : upstream entry (instr, pc, ext_src), in_ready is a flop output
//   out_*  : main-register contents (imm, fmt, target, tgt_valid, illegal)
//   flush  : drops both buffered entries on the next edge
// Buffering is a main output register plus one skid register so in_ready
// never depends combinationally on out_ready.
module risc_imm_stage
  import risc_imm_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit USE_EXT_SRC = 1'b0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [2:0]            ext_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_fmt,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic                  out_tgt_valid,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] target;
    imm_fmt_t              fmt;
    logic                  tgt_valid;
    logic                  illegal;
  } ent_t;

  logic [DATA_WIDTH-1:0] dec_imm, dec_target;
  imm_fmt_t              dec_fmt;
  logic                  dec_tgt_valid, dec_illegal;
  ent_t                  dec_ent;

  ent_t main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic acc, drain;

  risc_imm_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .USE_EXT_SRC(USE_EXT_SRC)
  ) u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .ext_src  (ext_src),
    .imm      (dec_imm),
    .fmt      (dec_fmt),
    .target   (dec_target),
    .tgt_valid(dec_tgt_valid),
    .illegal  (dec_illegal)
  );

  always_comb begin
    dec_ent = '{imm: dec_imm, target: dec_target, fmt: dec_fmt,
                tgt_valid: dec_tgt_valid, illegal: dec_illegal};

    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    acc        = in_valid && !skid_vld_q;
    drain      = main_vld_q && out_ready;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      // Main is free this cycle. A full skid implies in_ready was low, so
      // refilling from skid and accepting never collide.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d     = dec_ent;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (acc) begin
      // Main is stalled: park the new entry so upstream sees the stall a
      // cycle later through the registered in_ready.
      skid_d     = dec_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready      = !skid_vld_q;
  assign out_valid     = main_vld_q;
  assign out_imm       = main_q.imm;
  assign out_fmt       = main_q.fmt;
  assign out_target    = main_q.target;
  assign out_tgt_valid = main_q.tgt_valid;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_risc_imm_stage.sv
module tb_risc_imm_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [2:0]  fmt;
    logic        tv;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [2:0]  ext_src = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm, out_target;
  logic [2:0]  out_fmt;
  logic        out_tgt_valid, out_illegal;

  // 64-bit instance with the external format select
  logic        v_in_valid = 1'b0;
  logic        v_in_ready;
  logic [31:0] v_instr = '0;
  logic [63:0] v_pc = '0;
  logic [2:0]  v_ext = '0;
  logic        v_flush = 1'b0;
  logic        v_out_valid;
  logic        v_out_ready = 1'b1;
  logic [63:0] v_imm, v_tgt;
  logic [2:0]  v_fmt;
  logic        v_tv, v_ill;

  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[12];
  vec_t sb[$];

  always #5 clk = ~clk;

  risc_imm_stage #(.DATA_WIDTH(32), .USE_EXT_SRC(1'b0)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .ext_src(ext_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_target(out_target),
    .out_tgt_valid(out_tgt_valid), .out_illegal(out_illegal)
  );

  risc_imm_stage #(.DATA_WIDTH(64), .USE_EXT_SRC(1'b1)) dut64 (
    .clk(clk), .nrst(nrst), .flush(v_flush),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_instr(v_instr),
    .in_pc(v_pc), .ext_src(v_ext),
    .out_valid(v_out_valid), .out_ready(v_out_ready), .out_imm(v_imm),
    .out_fmt(v_fmt), .out_target(v_tgt),
    .out_tgt_valid(v_tv), .out_illegal(v_ill)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every output transfer pops one expected entry.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got imm 0x%0h expected no entry", out_imm);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("out_imm",       {32'b0, out_imm},       {32'b0, e.imm});
        chk("out_target",    {32'b0, out_target},    {32'b0, e.tgt});
        chk("out_fmt",       {61'b0, out_fmt},       {61'b0, e.fmt});
        chk("out_tgt_valid", {63'b0, out_tgt_valid}, {63'b0, e.tv});
        chk("out_illegal",   {63'b0, out_illegal},   {63'b0, e.ill});
      end
    end
  end

  task automatic send(input vec_t v);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = v.pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb.size() != 0 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic run64(input logic [31:0] ins, input logic [63:0] pc, input logic [2:0] ext,
                       input logic [63:0] e_imm, input logic [63:0] e_tgt,
                       input logic [2:0] e_fmt, input logic e_tv, input logic e_ill);
    v_in_valid = 1'b1;
    v_instr    = ins;
    v_pc       = pc;
    v_ext      = ext;
    @(posedge clk); #1;
    v_in_valid = 1'b0;
    @(negedge clk);
    chk("v64_valid", {63'b0, v_out_valid}, 64'd1);
    chk("v64_imm",   v_imm, e_imm);
    chk("v64_tgt",   v_tgt, e_tgt);
    chk("v64_fmt",   {61'b0, v_fmt}, {61'b0, e_fmt});
    chk("v64_tv",    {63'b0, v_tv},  {63'b0, e_tv});
    chk("v64_ill",   {63'b0, v_ill}, {63'b0, e_ill});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    //               instr         pc            imm           target       fmt  tv    ill
    vecs[0]  = '{32'hFFF00093, 32'h0000_0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0}; // addi
    vecs[1]  = '{32'h00112623, 32'h0000_0004, 32'h0000000C, 32'h00000010, 3'd1, 1'b0, 1'b0}; // sw
    vecs[2]  = '{32'h3400D073, 32'h0000_0008, 32'h00000001, 32'h00000009, 3'd5, 1'b0, 1'b0}; // csrrwi
    vecs[3]  = '{32'hFE000EE3, 32'h0000_0100, 32'hFFFFFFFC, 32'h000000FC, 3'd2, 1'b1, 1'b0}; // beq
    vecs[4]  = '{32'h008000EF, 32'h0000_0200, 32'h00000008, 32'h00000208, 3'd3, 1'b1, 1'b0}; // jal
    vecs[5]  = '{32'h123450B7, 32'h0000_0300, 32'h12345000, 32'h12345300, 3'd4, 1'b0, 1'b0}; // lui
    vecs[6]  = '{32'h00001097, 32'h0000_0400, 32'h00001000, 32'h00001400, 3'd4, 1'b1, 1'b0}; // auipc
    vecs[7]  = '{32'h0000007F, 32'h0000_0500, 32'h00000000, 32'h00000500, 3'd7, 1'b0, 1'b1}; // none
    vecs[8]  = '{32'h34001073, 32'h0000_0000, 32'h00000340, 32'h00000340, 3'd0, 1'b0, 1'b0}; // csrrw
    vecs[9]  = '{32'hFE002FA3, 32'h0000_0010, 32'hFFFFFFFF, 32'h0000000F, 3'd1, 1'b0, 1'b0}; // sw -1
    vecs[10] = '{32'hFFC080E7, 32'h0000_0020, 32'hFFFFFFFC, 32'h0000001C, 3'd0, 1'b0, 1'b0}; // jalr
    vecs[11] = '{32'h0040A103, 32'h0000_0030, 32'h00000004, 32'h00000034, 3'd0, 1'b0, 1'b0}; // lw

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid},     64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},      64'd1);
    chk("rst_out_imm",   {32'b0, out_imm},       64'd0);
    chk("rst_out_tgt",   {32'b0, out_target},    64'd0);
    chk("rst_out_fmt",   {61'b0, out_fmt},       64'd0);
    chk("rst_out_tv",    {63'b0, out_tgt_valid}, 64'd0);
    chk("rst_out_ill",   {63'b0, out_illegal},   64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    out_ready = 1'b1;

    // Latency 1 on the first entry, then a back-to-back stream
    send(vecs[0]);
    @(negedge clk);
    chk("latency1_valid", {63'b0, out_valid}, 64'd1);
    @(posedge clk); #1;
    for (int k = 1; k < 12; k++) send(vecs[k]);
    wait_drain();

    // Backpressure: four entries, consumer stalled for three cycles
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(vecs[k]);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("bp_ready_after_1st", {63'b0, in_ready}, 64'd1);
        chk("bp_hold_imm_a",      {32'b0, out_imm}, {32'b0, vecs[0].imm});
        @(negedge clk);
        chk("bp_ready_after_2nd", {63'b0, in_ready},  64'd0);
        chk("bp_hold_valid",      {63'b0, out_valid}, 64'd1);
        chk("bp_hold_imm_b",      {32'b0, out_imm},   {32'b0, vecs[0].imm});
        chk("bp_hold_tgt",        {32'b0, out_target}, {32'b0, vecs[0].tgt});
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("bp_no_bubble", {63'b0, out_valid}, 64'd1);
          if (c == 1) chk("bp_ready_rise", {63'b0, in_ready}, 64'd1);
        end
      end
    join
    wait_drain();

    // Flush with both entries full and a new entry offered
    out_ready = 1'b0;
    send(vecs[5]);
    send(vecs[6]);
    @(negedge clk);
    chk("fl_full_ready", {63'b0, in_ready},  64'd0);
    chk("fl_full_valid", {63'b0, out_valid}, 64'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = vecs[7].instr;
    in_pc    = vecs[7].pc;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_in_ready",  {63'b0, in_ready},  64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fl_nothing_after", {63'b0, out_valid}, 64'd0);
    end

    // Flush while an in-transfer would otherwise land in an empty stage
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = vecs[4].instr;
    in_pc    = vecs[4].pc;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_in_dropped", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset with a held entry
    out_ready = 1'b0;
    send(vecs[3]);
    @(negedge clk);
    chk("mid_pre_valid", {63'b0, out_valid}, 64'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'b0, out_valid},     64'd0);
    chk("mid_rst_imm",   {32'b0, out_imm},       64'd0);
    chk("mid_rst_tgt",   {32'b0, out_target},    64'd0);
    chk("mid_rst_tv",    {63'b0, out_tgt_valid}, 64'd0);
    chk("mid_rst_ready", {63'b0, in_ready},      64'd1);
    sb.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // 64-bit, external format select
    run64(32'h800000B7, 64'h1000, 3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 3'd4, 1'b0, 1'b0);
    run64(32'hFFF00093, 64'h0,    3'd6, 64'h0,                64'h0,                3'd7, 1'b0, 1'b1);
    run64(32'hFE000EE3, 64'h100,  3'd2, 64'hFFFFFFFFFFFFFFFC, 64'hFC,               3'd2, 1'b1, 1'b0);
    run64(32'h00001097, 64'h400,  3'd4, 64'h1000,             64'h1400,             3'd4, 1'b0, 1'b0);
    run64(32'h0000007F, 64'h40,   3'd0, 64'h0,                64'h40,               3'd0, 1'b0, 1'b0);
    run64(32'h3400D073, 64'h8,    3'd5, 64'h1,                64'h9,                3'd5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_imm_stage.md
Name: risc_imm_stage

Overview:
- Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage. Successor to the combinational immediate extender.
- Derives the immediate format from the opcode itself, or takes it from the control unit when overridden. Adds U-type and CSR zimm formats.
- Computes the PC-relative target for B, J and AUIPC.
- Sits between fetch and execute behind a valid/ready handshake, with a 2-entry skid buffer so backpressure never creates a combinational ready path.

Parameters:
- DATA_WIDTH, 32, XLEN. Legal values are 32 or 64. The immediate is sign-extended to DATA_WIDTH (zimm is zero-extended).
- USE_EXT_SRC, 0, 1 selects ext_src as the format; 0 selects opcode-derived decode.

Ports:
- clk  input  1  clock, rising edge
- nrst  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry
- in_instr  input  32  instruction word
- in_pc  input  DATA_WIDTH  PC of instruction
- ext_src  input  3  external format (imm_fmt_t); used only when USE_EXT_SRC=1
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_imm  output  DATA_WIDTH  extended immediate
- out_fmt  output  3  format used (imm_fmt_t)
- out_target  output  DATA_WIDTH  in_pc + out_imm, wrap modulo 2^DATA_WIDTH
- out_tgt_valid  output  1  target meaningful (B, J, AUIPC)
- out_illegal  output  1  opcode has no immediate mapping

Behaviour:
- Reset (nrst low, asynchronous): both buffer entries invalid. out_valid=0, in_ready=1. out_imm, out_target, out_fmt, out_tgt_valid and out_illegal are all 0.
- Format encoding: I=0, S=1, B=2, J=3, U=4, Z=5, NONE=7. Value 6 is reserved and treated as NONE.
- Extension rules:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - U: sext({instr[31:12], 12'b0}); sign extension matters for DATA_WIDTH=64
  - Z: zext(instr[19:15])
  - NONE: 0, with out_illegal=1
- Opcode decode (USE_EXT_SRC=0), using instr[6:0]:
  - 0010011, 0000011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111, 0010111 -> U
  - 1110011 -> Z if funct3[2]=1, else I
  - anything else -> NONE
- Target: out_target is always computed. out_tgt_valid=1 only for fmt B, fmt J, or opcode 0010111. With USE_EXT_SRC=1 it is 1 for B and J only.
- Handshake:
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - out_valid must not depend combinationally on out_ready.
  - Output data is stable while out_valid && !out_ready.
- Buffer: an output register (main) plus a skid register.
  - in_ready is registered and equals !skid_valid.
  - Accept while main is empty or draining: the entry goes to main and is visible the next cycle (latency 1).
  - Accept while main is held (out_valid && !out_ready): the entry goes to skid, and in_ready drops the next cycle.
  - Main drains while skid is full: skid moves to main, and in_ready rises the next cycle.
  - Simultaneous accept, drain and skid-empty: the new entry overwrites main. There is no bubble, giving a throughput of 1 per cycle.
- Flush: on the next edge both entries are invalidated and in_ready goes to 1. An in-transfer in the same cycle is discarded. An out-transfer in the same cycle still completes.
- Reset mid-operation clears everything immediately. There is no partial output.
- Order is strictly FIFO. There is no drop or duplication except under flush.

Decomposition:
- Package risc_imm_pkg holds:
  - imm_fmt_t (3-bit enum: I, S, B, J, U, Z, NONE)
  - opcode localparams: OP_IMM, LOAD, JALR, STORE, BRANCH, JAL, LUI, AUIPC, SYSTEM
  - function imm_ext(fmt, instr, width)
- One sub-module, risc_imm_decode: combinational opcode-to-fmt, immediate, target and flags, instantiated once at the input.
- Top level is the skid-buffer control plus registers.

Test Plan:
- Reset, then addi 0xFFF00093, pc 0x0: next cycle out_imm=0xFFFFFFFF, fmt=I, tgt_valid=0, illegal=0.
- sw 0x00112623 -> imm=0x0000000C, fmt=S. csrrwi 0x3400D073 -> imm=0x00000001, fmt=Z.
- beq 0xFE000EE3, pc=0x100 -> imm=0xFFFFFFFC, target=0x000000FC, tgt_valid=1. jal 0x008000EF, pc=0x200 -> imm=8, target=0x208.
- lui 0x123450B7 at DATA_WIDTH=32 -> imm=0x12345000. lui 0x800000B7 at DATA_WIDTH=64 -> imm=0xFFFFFFFF80000000. Opcode 0x0000007F -> imm=0, illegal=1.
- Backpressure: stream 4 instructions with in_valid=1 and out_ready=0 for 3 cycles. Required:
  - in_ready falls after the 2nd accept.
  - out data stays stable.
  - After out_ready=1, all 4 appear in order with no bubble once steady.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears. Assert nrst low mid-stream -> outputs are 0 immediately.
